display_mux_nseg: RTL

- Parametrised time-multiplexed driver for N-digit common-anode 7-segment displays.
- Scans one digit per refresh slot and decodes its 4-bit hex nibble to active-low segments.
- Adds per-digit enable, decimal points, leading-zero blanking and PWM brightness control.
- Sits between the datapath that produces display values and the board's anode/segment pins.

---
 rtl/disp_pkg.sv | 14 +
 rtl/seg7_hex_dec.sv | 12 +
 rtl/display_mux_nseg.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Shared types and constants for the multiplexed 7-segment display driver.
// Segment patterns are active-low {g,f,e,d,c,b,a} for a common-anode part.
package disp_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;

    localparam seg_t HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg7_hex_dec.sv
// Hex nibble to active-low 7-segment pattern.
// Latency: combinational. Backpressure: none.
module seg7_hex_dec
    import disp_pkg::*;
(
    input  logic [3:0] nib,
    output seg_t       seg
);

    assign seg = HEX_SEG[nib];

endmodule

// File: rtl/display_mux_nseg.sv
// Time-multiplexed N-digit common-anode 7-seg driver with blanking, dp and PWM dimming.
// Latency: outputs registered, 1 cycle behind scan state and live inputs. Backpressure: none.
// Optional blink of masked digits every BLINK_SCANS scans under DISPLAY_MUX_NSEG_BLINK_EN.
module display_mux_nseg
    import disp_pkg::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 1350,
    parameter int PWM_BITS    = 3
`ifdef DISPLAY_MUX_NSEG_BLINK_EN
    ,
    parameter int BLINK_SCANS = 64
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*N_DIGITS-1:0]   digits,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic [N_DIGITS-1:0]     digit_en,
    input  logic                    blank_lz,
    input  logic [PWM_BITS-1:0]     brightness,
`ifdef DISPLAY_MUX_NSEG_BLINK_EN
    input  logic [N_DIGITS-1:0]     blink_mask,
`endif
    output logic [N_DIGITS-1:0]     anodo,
    output logic [6:0]              seven,
    output logic                    dp
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int SEL_W = $clog2(N_DIGITS);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [N_DIGITS-1:0] anodo_q, anodo_d;
    seg_t                seven_q, seven_d;
    logic                dp_q, dp_d;

    logic        slot_end, scan_end;
    logic [3:0]  nib;
    logic        en_bit, dp_bit, lz, visible;
    logic [31:0] on_len;
    seg_t        seg_dec;

`ifdef DISPLAY_MUX_NSEG_BLINK_EN
    localparam int BLK_W = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;
    logic [BLK_W-1:0] scans_q, scans_d;
    logic             phase_q, phase_d;
    logic             blink_bit;
`endif

    always_comb begin
        slot_end = (cnt_q == CNT_W'(REFRESH_DIV - 1));
        scan_end = slot_end && (sel_q == SEL_W'(N_DIGITS - 1));
        cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
        sel_d    = sel_q;
        if (slot_end) begin
            sel_d = scan_end ? '0 : sel_q + 1'b1;
        end
    end

`ifdef DISPLAY_MUX_NSEG_BLINK_EN
    always_comb begin
        scans_d = scans_q;
        phase_d = phase_q;
        if (scan_end) begin
            if (scans_q == BLK_W'(BLINK_SCANS - 1)) begin
                scans_d = '0;
                phase_d = ~phase_q;
            end else begin
                scans_d = scans_q + 1'b1;
            end
        end
    end
`endif

    // A digit is a leading zero when it and every digit above it are zero; digit 0 never is.
    always_comb begin
        nib    = 4'h0;
        en_bit = 1'b0;
        dp_bit = 1'b0;
        lz     = blank_lz && (sel_q != '0);
`ifdef DISPLAY_MUX_NSEG_BLINK_EN
        blink_bit = 1'b0;
`endif
        for (int j = 0; j < N_DIGITS; j++) begin
            if (SEL_W'(j) == sel_q) begin
                nib    = digits[4*j +: 4];
                en_bit = digit_en[j];
                dp_bit = dp_in[j];
`ifdef DISPLAY_MUX_NSEG_BLINK_EN
                blink_bit = blink_mask[j];
`endif
            end
            if (SEL_W'(j) >= sel_q && digits[4*j +: 4] != 4'h0) begin
                lz = 1'b0;
            end
        end
    end

    seg7_hex_dec u_dec (
        .nib (nib),
        .seg (seg_dec)
    );

    always_comb begin
        on_len  = ((32'(brightness) + 32'd1) * 32'(REFRESH_DIV)) >> PWM_BITS;
        visible = en_bit && !lz && (32'(cnt_q) < on_len);
`ifdef DISPLAY_MUX_NSEG_BLINK_EN
        visible = visible && !(phase_q && blink_bit);
`endif
        anodo_d = '1;
        seven_d = SEG_BLANK;
        dp_d    = 1'b1;
        if (visible) begin
            anodo_d = ~(N_DIGITS'(1) << sel_q);
            seven_d = seg_dec;
            dp_d    = ~dp_bit;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            sel_q   <= '0;
            anodo_q <= '1;
            seven_q <= SEG_BLANK;
            dp_q    <= 1'b1;
`ifdef DISPLAY_MUX_NSEG_BLINK_EN
            scans_q <= '0;
            phase_q <= 1'b0;
`endif
        end else begin
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            anodo_q <= anodo_d;
            seven_q <= seven_d;
            dp_q    <= dp_d;
`ifdef DISPLAY_MUX_NSEG_BLINK_EN
            scans_q <= scans_d;
            phase_q <= phase_d;
`endif
        end
    end

    assign anodo = anodo_q;
    assign seven = seven_q;
    assign dp    = dp_q;

endmodule
